// File: rtl/elec_lane_training_ctrl_pkg.sv
// Shared types and defaults for the electrical-layer lane training controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   os_type_e     - ordered-set types exchanged with the lane driver
//   lt_state_e    - training state encoding exposed on lt_state
//   state_to_os() - OS transmitted in each training state
//   is_training() - true for the four states that transmit ordered sets
package elec_lt_pkg;

    typedef enum logic [2:0] {
        OS_NONE  = 3'd0,
        OS_SLOS1 = 3'd1,
        OS_SLOS2 = 3'd2,
        OS_TS1   = 3'd3,
        OS_TS2   = 3'd4
    } os_type_e;

    typedef enum logic [2:0] {
        LT_IDLE  = 3'd0,
        LT_SLOS1 = 3'd1,
        LT_SLOS2 = 3'd2,
        LT_TS1   = 3'd3,
        LT_TS2   = 3'd4,
        LT_CL0   = 3'd5
    } lt_state_e;

    // Default training parameters
    localparam int TX_MIN_OS_DEF   = 16;
    localparam int RX_REQ_OS_DEF   = 2;
    localparam int TIMEOUT_CYC_DEF = 4096;

    // OS that both sides exchange while in a given state; OS_NONE outside training.
    function automatic os_type_e state_to_os(input lt_state_e s);
        os_type_e os;
        case (s)
            LT_SLOS1: os = OS_SLOS1;
            LT_SLOS2: os = OS_SLOS2;
            LT_TS1:   os = OS_TS1;
            LT_TS2:   os = OS_TS2;
            default:  os = OS_NONE;
        endcase
        return os;
    endfunction

    function automatic logic is_training(input lt_state_e s);
        return (s == LT_SLOS1) || (s == LT_SLOS2) || (s == LT_TS1) || (s == LT_TS2);
    endfunction

endpackage

// File: rtl/elec_lane_training_ctrl_if.sv
// Ordered-set bundle between the training controller and the lane.
// Latency: n/a (wires only).
// Backpressure: tx_os_ready from the driver stalls the transmit request.
//
// Signals:
//   tx_os_valid/tx_os_type/tx_os_ready - OS transmit request handshake
//   rx_os_valid/rx_os_type             - OS decoded by the receive path
// Modports:
//   master - controller side (drives the tx request, observes rx)
//   slave  - lane side (accepts the tx request, reports rx)
interface elec_lane_training_ctrl_if;
    import elec_lt_pkg::*;

    logic     tx_os_valid;
    os_type_e tx_os_type;
    logic     tx_os_ready;
    logic     rx_os_valid;
    os_type_e rx_os_type;

    modport master (
        output tx_os_valid,
        output tx_os_type,
        input  tx_os_ready,
        input  rx_os_valid,
        input  rx_os_type
    );

    modport slave (
        input  tx_os_valid,
        input  tx_os_type,
        output tx_os_ready,
        output rx_os_valid,
        output rx_os_type
    );

endinterface

// File: rtl/elec_lane_training_ctrl_os_consec_counter.sv
// Saturating counter of consecutive matching partner ordered sets.
// Latency: cnt_nxt is combinational (includes this cycle's match/mismatch).
// Backpressure: none; holds its value when neither match nor mismatch.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - synchronous clear, wins over match/mismatch
//   match     - a matching OS was received this cycle
//   mismatch  - a non-matching OS was received this cycle (restarts the run)
//   cnt_nxt   - count including this cycle's input
module os_consec_counter #(
    parameter int MAX = 2,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         match,
    input  logic         mismatch,
    output logic [W-1:0] cnt_nxt
);

    logic [W-1:0] cnt;

    // A mismatch breaks the run even if a match is also flagged.
    always_comb begin
        cnt_nxt = cnt;
        if (mismatch) begin
            cnt_nxt = '0;
        end else if (match && (cnt != W'(MAX))) begin
            cnt_nxt = cnt + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/elec_lane_training_ctrl.sv
// USB4 electrical lane training sequencer: SLOS1 -> SLOS2 -> TS1 -> TS2 -> CL0.
// Latency: state advances on the edge closing the qualifying handshake; next OS type
//          is presented the following cycle with tx_os_valid kept high.
// Backpressure: tx_os_ready low stalls tx counting; tx_os_type is held until accepted.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   lt_start          - start pulse, only honoured in IDLE
//   lt_abort          - forces IDLE from any state, highest priority
//   gen_sel           - 0 = Gen2, 1 = Gen3 (SLOS2 skipped); captured at start
//   os_if             - ordered-set tx handshake and rx report (master side)
//   tx_data_en        - lane handed to the transport datapath (CL0)
//   lt_state          - current training state
//   lt_done / lt_fail - one-cycle pulses on CL0 entry / per-state timeout
module elec_lane_training_ctrl
    import elec_lt_pkg::*;
#(
    parameter int TX_MIN_OS   = TX_MIN_OS_DEF,
    parameter int RX_REQ_OS   = RX_REQ_OS_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             lt_start,
    input  logic                             lt_abort,
    input  logic                             gen_sel,
    elec_lane_training_ctrl_if.master        os_if,
    output logic                             tx_data_en,
    output lt_state_e                        lt_state,
    output logic                             lt_done,
    output logic                             lt_fail
);

    localparam int TX_W = $clog2(TX_MIN_OS + 1);
    localparam int RX_W = $clog2(RX_REQ_OS + 1);

    lt_state_e        state;
    lt_state_e        state_nxt;
    logic             gen3;

    logic             training;
    os_type_e         cur_os;
    logic             hs;
    logic             entry;
    logic             cnt_clr;
    logic             timeout;
    logic             exit_ok;

    logic [TX_W-1:0]  tx_cnt;
    logic [TX_W-1:0]  tx_cnt_nxt;
    logic [RX_W-1:0]  rx_cnt_nxt;
    logic [CNT_W-1:0] to_cnt;

    logic             rx_match;
    logic             rx_mismatch;

    // ------------------------------------------------------------------
    // Per-state qualifiers
    // ------------------------------------------------------------------
    always_comb begin
        training = is_training(state);
        cur_os   = state_to_os(state);
        // tx_os_valid equals training, so the handshake needs only ready here.
        hs       = training && os_if.tx_os_ready;
        // rx reports are meaningless outside training and are dropped there.
        rx_match    = training && os_if.rx_os_valid && (os_if.rx_os_type == cur_os);
        rx_mismatch = training && os_if.rx_os_valid && (os_if.rx_os_type != cur_os);
        timeout  = training && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
    end

    always_comb begin
        tx_cnt_nxt = tx_cnt;
        if (hs && (tx_cnt != TX_W'(TX_MIN_OS))) begin
            tx_cnt_nxt = tx_cnt + TX_W'(1);
        end
    end

    // Exit needs a handshake in this very cycle; satisfied counts alone wait for one.
    assign exit_ok = hs
                  && (tx_cnt_nxt == TX_W'(TX_MIN_OS))
                  && (rx_cnt_nxt == RX_W'(RX_REQ_OS));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LT_IDLE;
            gen3    <= 1'b0;
            lt_done <= 1'b0;
            lt_fail <= 1'b0;
        end else begin
            state   <= state_nxt;
            if ((state == LT_IDLE) && lt_start && !lt_abort) begin
                gen3 <= gen_sel;
            end
            lt_done <= (state_nxt == LT_CL0) && (state != LT_CL0);
            // Abort outranks timeout, so it also suppresses the fail pulse.
            lt_fail <= timeout && !lt_abort;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (lt_abort) begin
            state_nxt = LT_IDLE;
        end else begin
            case (state)
                LT_IDLE: begin
                    if (lt_start) begin
                        state_nxt = LT_SLOS1;
                    end
                end
                LT_SLOS1: begin
                    if (timeout) begin
                        state_nxt = LT_IDLE;
                    end else if (exit_ok) begin
                        state_nxt = gen3 ? LT_TS1 : LT_SLOS2;
                    end
                end
                LT_SLOS2: begin
                    if (timeout) begin
                        state_nxt = LT_IDLE;
                    end else if (exit_ok) begin
                        state_nxt = LT_TS1;
                    end
                end
                LT_TS1: begin
                    if (timeout) begin
                        state_nxt = LT_IDLE;
                    end else if (exit_ok) begin
                        state_nxt = LT_TS2;
                    end
                end
                LT_TS2: begin
                    if (timeout) begin
                        state_nxt = LT_IDLE;
                    end else if (exit_ok) begin
                        state_nxt = LT_CL0;
                    end
                end
                LT_CL0: begin
                    state_nxt = LT_CL0;
                end
                default: begin
                    state_nxt = LT_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        os_if.tx_os_valid = training;
        os_if.tx_os_type  = training ? cur_os : OS_NONE;
        tx_data_en        = (state == LT_CL0);
        lt_state          = state;
    end

    // ------------------------------------------------------------------
    // Counters: all three restart on every state entry and idle at zero
    // outside the training states.
    // ------------------------------------------------------------------
    assign entry   = (state_nxt != state);
    assign cnt_clr = entry || !training;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt <= '0;
            to_cnt <= '0;
        end else if (cnt_clr) begin
            tx_cnt <= '0;
            to_cnt <= '0;
        end else begin
            tx_cnt <= tx_cnt_nxt;
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    os_consec_counter #(
        .MAX (RX_REQ_OS),
        .W   (RX_W)
    ) u_rx_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .match    (rx_match),
        .mismatch (rx_mismatch),
        .cnt_nxt  (rx_cnt_nxt)
    );

endmodule

// File: tb/tb_elec_lane_training_ctrl.sv
// Testbench for elec_lane_training_ctrl: directed scenarios plus randomized
// traffic compared against a sequence-list reference model.
module tb_elec_lane_training_ctrl;
    import elec_lt_pkg::*;

    localparam int TXM = 4;
    localparam int RXR = 2;
    localparam int TO  = 64;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       lt_start = 1'b0;
    logic       lt_abort = 1'b0;
    logic       gen_sel  = 1'b0;
    logic       tx_data_en;
    logic       lt_done;
    logic       lt_fail;
    logic [2:0] lt_state;

    int errors = 0;
    int checks = 0;

    elec_lane_training_ctrl_if os_if();

    elec_lane_training_ctrl #(
        .TX_MIN_OS   (TXM),
        .RX_REQ_OS   (RXR),
        .TIMEOUT_CYC (TO)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .lt_start   (lt_start),
        .lt_abort   (lt_abort),
        .gen_sel    (gen_sel),
        .os_if      (os_if),
        .tx_data_en (tx_data_en),
        .lt_state   (lt_state),
        .lt_done    (lt_done),
        .lt_fail    (lt_fail)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: training is a list of OS types walked by index.
    // m_pos = -1 is IDLE, m_pos = m_n is CL0; state code equals OS code.
    // ------------------------------------------------------------------
    int m_seq[4] = '{1, 2, 3, 4};
    int m_n      = 4;
    int m_pos    = -1;
    int m_tx     = 0;
    int m_rx     = 0;
    int m_to     = 0;
    bit m_done   = 1'b0;
    bit m_fail   = 1'b0;

    function automatic bit m_training();
        return (m_pos >= 0) && (m_pos < m_n);
    endfunction

    function automatic int exp_state();
        if (m_pos < 0) return 0;
        if (m_pos >= m_n) return 5;
        return m_seq[m_pos];
    endfunction

    function automatic int exp_os();
        return m_training() ? m_seq[m_pos] : 0;
    endfunction

    task automatic model_reset();
        m_pos = -1; m_tx = 0; m_rx = 0; m_to = 0; m_done = 0; m_fail = 0;
    endtask

    task automatic model_step();
        int cur, tx_after, rx_after;
        m_done = 0;
        m_fail = 0;
        if (lt_abort) begin
            m_pos = -1; m_tx = 0; m_rx = 0; m_to = 0;
        end else if (m_pos < 0) begin
            if (lt_start) begin
                if (gen_sel) begin m_seq = '{1, 3, 4, 0}; m_n = 3; end
                else         begin m_seq = '{1, 2, 3, 4}; m_n = 4; end
                m_pos = 0; m_tx = 0; m_rx = 0; m_to = 0;
            end
        end else if (m_training()) begin
            cur      = m_seq[m_pos];
            tx_after = m_tx + (os_if.tx_os_ready ? 1 : 0);
            if (tx_after > TXM) tx_after = TXM;
            rx_after = m_rx;
            if (os_if.rx_os_valid) begin
                if (int'(os_if.rx_os_type) == cur) rx_after = (m_rx + 1 > RXR) ? RXR : m_rx + 1;
                else                               rx_after = 0;
            end
            if (m_to == TO - 1) begin
                m_pos = -1; m_fail = 1; m_tx = 0; m_rx = 0; m_to = 0;
            end else if (os_if.tx_os_ready && tx_after == TXM && rx_after == RXR) begin
                m_pos = m_pos + 1; m_tx = 0; m_rx = 0; m_to = 0;
                if (m_pos == m_n) m_done = 1;
            end else begin
                m_tx = tx_after; m_rx = rx_after; m_to = m_to + 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else     model_step();
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lt_start = 0; lt_abort = 0;
        os_if.tx_os_ready = 0;
        os_if.rx_os_valid = 0;
        os_if.rx_os_type  = OS_NONE;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        tick();
    endtask

    task automatic start_training(input bit g);
        gen_sel  = g;
        lt_start = 1;
        tick();
        lt_start = 0;
    endtask

    // Four handshakes with two matching partner OSes: the minimum-length state.
    task automatic pass_state(input int s);
        for (int c = 0; c < TXM; c++) begin
            os_if.tx_os_ready = 1;
            os_if.rx_os_valid = (c < RXR);
            os_if.rx_os_type  = os_type_e'(s);
            tick();
        end
        os_if.rx_os_valid = 0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        checks++;
        if (lt_state !== 3'd0 || os_if.tx_os_valid !== 1'b0 || os_if.tx_os_type !== OS_NONE ||
            tx_data_en !== 1'b0 || lt_done !== 1'b0 || lt_fail !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d valid=%0b type=%0d den=%0b done=%0b fail=%0b, required all 0",
                     lt_state, os_if.tx_os_valid, os_if.tx_os_type, tx_data_en, lt_done, lt_fail);
        end
        @(negedge clk);
        rst = 0;
        tick();
        checks++;
        if (lt_state !== 3'd0) begin
            errors++;
            $display("FAIL idle_after_reset: state=%0d required 0", lt_state);
        end
    endtask

    task automatic run_happy(input bit g, input string tag);
        int seq[4];
        int n, done_cnt;
        bit saw2;
        if (g) begin seq = '{1, 3, 4, 0}; n = 3; end
        else   begin seq = '{1, 2, 3, 4}; n = 4; end
        done_cnt = 0;
        saw2     = 0;
        do_reset();
        start_training(g);
        gen_sel = ~g;   // must not matter once training has begun
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c < TXM; c++) begin
                os_if.tx_os_ready = 1;
                os_if.rx_os_valid = (c < RXR);
                os_if.rx_os_type  = os_type_e'(seq[s]);
                if (lt_state == 3'd2 || os_if.tx_os_type == OS_SLOS2) saw2 = 1;
                checks++;
                if (lt_state !== 3'(seq[s]) || os_if.tx_os_type !== 3'(seq[s]) || os_if.tx_os_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_walk s%0d c%0d: state=%0d type=%0d valid=%0b, required state=type=%0d valid=1",
                             tag, s, c, lt_state, os_if.tx_os_type, os_if.tx_os_valid, seq[s]);
                end
                if (lt_done) done_cnt++;
                tick();
            end
        end
        os_if.rx_os_valid = 0;
        checks++;
        if (lt_state !== 3'd5 || lt_done !== 1'b1 || tx_data_en !== 1'b1 || os_if.tx_os_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_cl0_entry: state=%0d done=%0b den=%0b valid=%0b, required 5/1/1/0",
                     tag, lt_state, lt_done, tx_data_en, os_if.tx_os_valid);
        end
        for (int k = 0; k < 6; k++) begin
            if (lt_done) done_cnt++;
            os_if.rx_os_valid = 1;
            os_if.rx_os_type  = os_type_e'(k % 5);
            tick();
        end
        os_if.rx_os_valid = 0;
        checks++;
        if (done_cnt !== 1 || lt_state !== 3'd5 || tx_data_en !== 1'b1) begin
            errors++;
            $display("FAIL %s_cl0_hold: done_pulses=%0d state=%0d den=%0b, required 1/5/1",
                     tag, done_cnt, lt_state, tx_data_en);
        end
        if (g) begin
            checks++;
            if (saw2) begin
                errors++;
                $display("FAIL gen3_skip: SLOS2 observed=%0b required 0", saw2);
            end
        end
    endtask

    task automatic test_gen2_happy();
        run_happy(1'b0, "gen2");
    endtask

    task automatic test_gen3_skip();
        run_happy(1'b1, "gen3");
    endtask

    task automatic test_rx_mismatch();
        int types[4] = '{3, 4, 3, 3};
        int exp_rx[4] = '{1, 0, 1, 2};
        do_reset();
        start_training(1'b0);
        pass_state(1);
        pass_state(2);
        for (int c = 0; c < 4; c++) begin
            os_if.tx_os_ready = 1;
            os_if.rx_os_valid = 1;
            os_if.rx_os_type  = os_type_e'(types[c]);
            #1;
            checks++;
            if (lt_state !== 3'd3 || u_dut.rx_cnt_nxt !== 2'(exp_rx[c])) begin
                errors++;
                $display("FAIL rx_mismatch c%0d: state=%0d rx_cnt=%0d, required 3/%0d",
                         c, lt_state, u_dut.rx_cnt_nxt, exp_rx[c]);
            end
            tick();
        end
        os_if.rx_os_valid = 0;
        checks++;
        if (lt_state !== 3'd4 || os_if.tx_os_type !== OS_TS2) begin
            errors++;
            $display("FAIL rx_mismatch_exit: state=%0d type=%0d, required 4/4", lt_state, os_if.tx_os_type);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        start_training(1'b0);
        for (int c = 0; c < 7; c++) begin
            os_if.tx_os_ready = (c % 2 == 0);
            os_if.rx_os_valid = (c < RXR);
            os_if.rx_os_type  = OS_SLOS1;
            checks++;
            if (lt_state !== 3'd1 || os_if.tx_os_type !== OS_SLOS1 || os_if.tx_os_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure c%0d: state=%0d type=%0d valid=%0b, required 1/1/1",
                         c, lt_state, os_if.tx_os_type, os_if.tx_os_valid);
            end
            tick();
        end
        os_if.rx_os_valid = 0;
        checks++;
        if (lt_state !== 3'd2 || os_if.tx_os_type !== OS_SLOS2 || os_if.tx_os_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_exit: state=%0d type=%0d valid=%0b, required 2/2/1",
                     lt_state, os_if.tx_os_type, os_if.tx_os_valid);
        end
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        do_reset();
        start_training(1'b0);
        os_if.tx_os_ready = 1;
        for (int c = 0; c < TO; c++) begin
            if (lt_state !== 3'd1 || lt_fail !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_hold: early exit cycles=%0d required 0", bad);
        end
        checks++;
        if (lt_state !== 3'd0 || lt_fail !== 1'b1 || os_if.tx_os_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: state=%0d fail=%0b valid=%0b, required 0/1/0",
                     lt_state, lt_fail, os_if.tx_os_valid);
        end
        tick();
        checks++;
        if (lt_fail !== 1'b0 || lt_state !== 3'd0) begin
            errors++;
            $display("FAIL timeout_pulse_len: fail=%0b state=%0d, required 0/0", lt_fail, lt_state);
        end
    endtask

    task automatic test_abort_reset();
        do_reset();
        start_training(1'b0);
        pass_state(1);
        pass_state(2);
        pass_state(3);
        for (int c = 0; c < TXM; c++) begin
            os_if.tx_os_ready = 1;
            os_if.rx_os_valid = (c < RXR);
            os_if.rx_os_type  = OS_TS2;
            lt_abort = (c == TXM - 1);
            tick();
        end
        lt_abort = 0;
        os_if.rx_os_valid = 0;
        checks++;
        if (lt_state !== 3'd0 || lt_done !== 1'b0 || tx_data_en !== 1'b0 || os_if.tx_os_valid !== 1'b0 ||
            lt_fail !== 1'b0) begin
            errors++;
            $display("FAIL abort_at_exit: state=%0d done=%0b den=%0b valid=%0b fail=%0b, required all 0",
                     lt_state, lt_done, tx_data_en, os_if.tx_os_valid, lt_fail);
        end
        lt_start = 1;
        lt_abort = 1;
        tick();
        lt_start = 0;
        lt_abort = 0;
        checks++;
        if (lt_state !== 3'd0 || lt_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_beats_start: state=%0d done=%0b, required 0/0", lt_state, lt_done);
        end
        start_training(1'b0);
        pass_state(1);
        pass_state(2);
        os_if.tx_os_ready = 1;
        tick();
        #2;
        rst = 1;
        #1;
        checks++;
        if (lt_state !== 3'd0 || os_if.tx_os_valid !== 1'b0 || os_if.tx_os_type !== OS_NONE ||
            tx_data_en !== 1'b0 || lt_done !== 1'b0 || lt_fail !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: state=%0d valid=%0b type=%0d den=%0b done=%0b fail=%0b, required all 0",
                     lt_state, os_if.tx_os_valid, os_if.tx_os_type, tx_data_en, lt_done, lt_fail);
        end
        @(negedge clk);
        rst = 0;
        idle_inputs();
        tick();
        checks++;
        if (lt_fail !== 1'b0 || lt_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_no_fail: fail=%0b state=%0d, required 0/0", lt_fail, lt_state);
        end
    endtask

    task automatic test_random();
        int bad;
        for (int run = 0; run < 6; run++) begin
            bad = 0;
            do_reset();
            for (int c = 0; c < 300; c++) begin
                lt_start = (m_pos < 0) && ($urandom_range(0, 3) == 0);
                lt_abort = ($urandom_range(0, 199) == 0);
                gen_sel  = 1'($urandom_range(0, 1));
                os_if.tx_os_ready = ($urandom_range(0, 3) != 0);
                os_if.rx_os_valid = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 9) < 8) os_if.rx_os_type = os_type_e'(exp_os());
                else                          os_if.rx_os_type = os_type_e'($urandom_range(0, 4));
                if (lt_state !== 3'(exp_state()) || os_if.tx_os_valid !== m_training() ||
                    os_if.tx_os_type !== 3'(exp_os()) || tx_data_en !== (m_pos == m_n) ||
                    lt_done !== m_done || lt_fail !== m_fail) begin
                    if (bad < 3)
                        $display("FAIL random r%0d c%0d: state=%0d/%0d valid=%0b type=%0d/%0d den=%0b done=%0b/%0b fail=%0b/%0b (dut/model)",
                                 run, c, lt_state, exp_state(), os_if.tx_os_valid, os_if.tx_os_type, exp_os(),
                                 tx_data_en, lt_done, m_done, lt_fail, m_fail);
                    bad++;
                end
                tick();
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random_run r%0d: mismatching cycles=%0d required 0", run, bad);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_gen2_happy();
        test_gen3_skip();
        test_rx_mismatch();
        test_backpressure();
        test_timeout();
        test_abort_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/elec_lane_training_ctrl.md
Name: elec_lane_training_ctrl

Overview:
Sequences the electrical-layer lane driver through USB4 lane training: SLOS1 -> SLOS2 -> TS1 -> TS2 -> CL0.
- Commands which ordered set (OS) the driver transmits, using a valid/ready handshake.
- Counts transmitted OSes and partner OSes received consecutively.
- Enforces a per-state timeout.
- Hands the lane to the transport datapath once CL0 is reached.

Parameters:
- TX_MIN_OS, 16: minimum OSes transmitted in each training state before exit.
- RX_REQ_OS, 2: consecutive matching partner OSes required before exit.
- TIMEOUT_CYC, 4096: cycles allowed per training state before failure.
- CNT_W, $clog2(TIMEOUT_CYC): width of the timeout counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- lt_start  in  1  one-cycle pulse that starts training. Honoured only in IDLE.
- lt_abort  in  1  level or pulse that forces IDLE from any state.
- gen_sel  in  1  0 = Gen2 (all states); 1 = Gen3 (SLOS2 skipped).
- rx_os_valid  in  1  the receive path has decoded one OS this cycle.
- rx_os_type  in  3  type of the decoded OS (os_type_e).
- tx_os_valid  out  1  request to transmit one OS.
- tx_os_type  out  3  type of the OS to transmit (os_type_e).
- tx_os_ready  in  1  driver accepts the OS; a handshake occurs when valid & ready.
- tx_data_en  out  1  lane owned by the transport datapath (CL0 only).
- lt_state  out  3  current state (lt_state_e).
- lt_done  out  1  one-cycle pulse on entry to CL0.
- lt_fail  out  1  one-cycle pulse on timeout.

Behaviour:
Reset:
- State = IDLE.
- All outputs = 0.
- All counters = 0.

States and transitions:
- IDLE -> SLOS1 on lt_start.
- SLOS1 -> SLOS2 when gen_sel=0; SLOS1 -> TS1 when gen_sel=1.
- SLOS2 -> TS1.
- TS1 -> TS2.
- TS2 -> CL0.
- CL0 holds until lt_abort.
- gen_sel is sampled at lt_start and held for the whole training sequence.

Training states (SLOS1, SLOS2, TS1, TS2):
- tx_os_valid = 1 and tx_os_type = the OS for that state.
- tx_os_type is stable while valid & !ready.

Counters:
- tx_cnt: +1 per handshake, saturates at TX_MIN_OS.
- rx_cnt increments (saturating at RX_REQ_OS) on rx_os_valid with rx_os_type equal to the current state's OS.
- rx_cnt clears to 0 on rx_os_valid with any other type.
- rx_cnt holds when rx_os_valid = 0.
- tx_cnt, rx_cnt and the timeout counter all clear on every state entry.

Exit condition:
- A state advances on the clock edge ending a handshake cycle in which tx_cnt (including this handshake) = TX_MIN_OS and rx_cnt (including this cycle's rx) = RX_REQ_OS.
- With no handshake in that cycle, the controller waits for the next handshake.
- The next state's tx_os_type appears in the cycle after the handshake. There is no bubble: tx_os_valid stays 1.

Timeout:
- The timeout counter increments every cycle in a training state.
- When it reaches TIMEOUT_CYC-1 without an exit, the next cycle is IDLE with lt_fail = 1 for one cycle.

Entering CL0:
- tx_os_valid = 0, tx_data_en = 1.
- lt_done = 1 for the first CL0 cycle only.

Priority when events coincide: lt_abort > timeout > normal advance.
- lt_abort gives IDLE on the next cycle with no lt_fail or lt_done pulse.
- Abort and timeout may drop tx_os_valid without a handshake; the driver tolerates this.

Other rules:
- lt_start outside IDLE is ignored.
- lt_start coincident with lt_abort in IDLE: abort wins and the controller stays in IDLE.
- rx OSes are ignored in IDLE and CL0.
- Reset asserted mid-training gives an immediate IDLE with all outputs 0. No lt_fail pulse.

Decomposition:
- Package elec_lt_pkg:
  - os_type_e: OS_NONE=0, OS_SLOS1=1, OS_SLOS2=2, OS_TS1=3, OS_TS2=4.
  - lt_state_e: LT_IDLE=0, LT_SLOS1=1, LT_SLOS2=2, LT_TS1=3, LT_TS2=4, LT_CL0=5.
  - Function state_to_os().
  - Default values for TX_MIN_OS, RX_REQ_OS and TIMEOUT_CYC.
- One sub-module, os_consec_counter: saturating consecutive-match counter with clear, match and mismatch inputs. Instantiated once for rx_cnt.

Test Plan:
All scenarios use TX_MIN_OS=4, RX_REQ_OS=2, TIMEOUT_CYC=64.
1. Gen2 happy path. gen_sel=0, lt_start, ready held 1, partner sends 2 matching OSes per state.
   Required: lt_state walks 1,2,3,4,5; each state lasts exactly 4 cycles; lt_done pulses once; tx_data_en=1; tx_os_valid=0.
2. Gen3 skip. gen_sel=1, same stimulus as scenario 1.
   Required: state 1 -> 3; SLOS2 is never driven.
3. rx mismatch reset. In TS1, partner sends TS1, TS2, TS1, TS1.
   Required: exit only after the final TS1; rx_cnt goes 1, 0, 1, 2.
4. Backpressure. In SLOS1, ready toggles 1010...
   Required: tx_os_type stays stable while ready=0; exit occurs on the 4th handshake (cycle 7).
5. Timeout. Partner stays silent in SLOS1.
   Required: lt_fail pulses in cycle 64 after entry, then lt_state=0 and tx_os_valid=0.
6. Abort/reset. lt_abort asserted in the same cycle as the exit of TS2.
   Required: IDLE, no lt_done. Then asynchronous rst mid-TS1: all outputs are 0 immediately.
